load_use_interlock_unit: RTL and testbench
==========================================

// Module: load_use_interlock_unit
// PURPOSE
//  Parametrised load-use interlock for the N-issue MIPS pipeline, sitting between the IF/ID and ID/EX registers.
//  Tracks the destinations of in-flight loads across a configurable load latency and compares them against every
//  ID-stage source. Stalls IF/ID and injects bubbles into ID/EX for exactly as long as needed.
//  Also splits a bundle when a later slot reads the destination of an earlier slot. Register $0 never causes a hazard.
// PARAMETERS
//  ISSUE_W   2   slots per bundle (1..4)
//  REG_AW    5   register index width
//  LOAD_LAT  1   cycles after EX before load data is forwardable (1..4)
//  WDOG_MAX  8   consecutive stall cycles before err_o is raised (must exceed LOAD_LAT)
//  CNT_W     32  stall counter width (STALL_CNT_EN only)
// PORTS
//  clk            in   1               clock
//  btnc_i         in   1               synchronous reset, active-high
//  id_valid_i     in   ISSUE_W         slot k of the ID bundle holds an instruction
//  id_rs_i        in   ISSUE_W*REG_AW  rs of slot k, at bits [k*REG_AW +: REG_AW]
//  id_rt_i        in   ISSUE_W*REG_AW  rt of slot k
//  id_rt_used_i   in   ISSUE_W         rt is a source operand (R-type, store, branch)
//  id_wr_i        in   ISSUE_W         slot k writes a register
//  id_wd_i        in   ISSUE_W*REG_AW  destination of slot k
//  ex_load_i      in   ISSUE_W         ID/EX slot k holds a load (MemRead)
//  ex_ld_rt_i     in   ISSUE_W*REG_AW  load destination of ID/EX slot k
//  stall_o        out  1               hold PC and IF/ID
//  bubble_o       out  1               load NOP into all ID/EX slots
//  issue_mask_o   out  ISSUE_W         slots allowed into ID/EX this cycle
//  err_o          out  1               sticky watchdog error
//  stall_cnt_o    out  CNT_W           total stall cycles (STALL_CNT_EN only)
// BEHAVIOUR
//  - Reset (btnc_i=1 at a clk edge): scoreboard cleared, FSM=RUN, wdog=0, err_o=0, stall_cnt_o=0.
//    While btnc_i=1: stall_o=0, bubble_o=0, issue_mask_o=0.
//  - Scoreboard: pending[a][k] {valid, rt} for ages a=1..LOAD_LAT-1. It shifts every clk, independent of stall,
//    because EX/MEM always advances. Age 0 is driven combinationally from ex_load_i/ex_ld_rt_i.
//    A pending entry with rt==0 is never valid.
//  - src_hit(k) = id_valid_i[k] & (rs match | (id_rt_used_i[k] & rt match)) against any valid entry of ages
//    0..LOAD_LAT-1. Matches require a nonzero index.
//  - stall_o = bubble_o = OR over k of src_hit(k). When stalled, issue_mask_o=0. The stall is combinational in the
//    same cycle, so detection-to-stall latency is 0. A load in EX with LOAD_LAT=L stalls a dependent ID for exactly L cycles.
//  - Intra-bundle: j is the lowest slot that reads (rs, or rt if used) a nonzero id_wd_i of a valid writing slot i<j.
//    If no stall: issue_mask_o = slots below j, and stall_o=1 so IF/ID re-presents slots >= j. bubble_o=0.
//    With no stall and no split: issue_mask_o = id_valid_i.
//  - Simultaneous load-use and split: the load-use stall wins, mask=0.
//  - FSM RUN/STALL: RUN->STALL when stall_o is due to src_hit. STALL->RUN when the hit clears.
//    wdog counts consecutive STALL cycles and saturates. At wdog==WDOG_MAX, err_o sets and stays set until reset.
//    The stall itself is not overridden.
//  - A split-only stall does not enter STALL and does not advance wdog.
//  - Reset mid-stall: the next cycle starts in RUN with an empty scoreboard. Only age-0 inputs can stall then.
// CONFIGURATION
//  STALL_CNT_EN defined: stall_cnt_o increments on every cycle with stall_o=1 (both causes) and wraps at 2^CNT_W.
//  STALL_CNT_EN undefined: stall_cnt_o is absent, with no counter flops.
// STRUCTURE
//  - Shared package pipe_pkg: REG_AW default, REG_ZERO constant, and the typedef for the pending entry {valid, rt}.
//  - One sub-module, reg_match_cmp: one source vs. the vector of pending entries, with $0 masking.
//    Instantiated 2*ISSUE_W times.
// TESTING
//  1. ISSUE_W=2, LOAD_LAT=1: EX slot0 lw $5; ID slot1 add rs=$5 -> stall_o=bubble_o=1 for 1 cycle, mask=00; then mask=11.
//  2. LOAD_LAT=3: EX lw $7, ID uses $7 as rt with rt_used=1 -> stall for exactly 3 cycles. Same test with rt_used=0 -> no stall.
//  3. EX lw $0, ID reads $0 -> no stall. ID slot0 writes $0, slot1 reads $0 -> mask=11, no split.
//  4. ID slot0 addi $9, slot1 sub rs=$9, no load pending -> mask=01, stall_o=1, bubble_o=0, FSM stays RUN.
//  5. Hold ex_load_i=1, rt=$4 with a dependent ID for 8 cycles (WDOG_MAX=8) -> err_o=1 and sticky.
//     Pulse btnc_i -> err_o=0, stall_cnt_o=0.
//  6. Mid-stall (LOAD_LAT=3, cycle 2) assert btnc_i with ex_load_i=0 -> next cycle stall_o=0, mask=id_valid_i.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the load-use interlock: register-index widths,
// the $0 constant, the pending-load scoreboard entry and the interlock FSM states.
package pipe_pkg;

    localparam int REG_AW_DEF = 5;
    // Scoreboard entries hold indices at this width so one entry type serves any REG_AW up to it.
    localparam int REG_AW_MAX = 8;

    localparam logic [REG_AW_MAX-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rt;
    } pend_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } lu_state_t;

endpackage

// File: rtl/reg_match_cmp.sv
// Compares one ID-stage source register against every pending load destination.
// A source of $0 never matches.
module reg_match_cmp
    import pipe_pkg::*;
#(
    parameter int NUM_ENT = 2
) (
    input  logic [REG_AW_MAX-1:0] src,
    input  pend_t [NUM_ENT-1:0]   ents,
    output logic                  hit
);

    always_comb begin
        hit = 1'b0;
        for (int e = 0; e < NUM_ENT; e++) begin
            if (ents[e].valid && (ents[e].rt == src)) begin
                hit = 1'b1;
            end
        end
        if (src == REG_ZERO) begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/load_use_interlock_unit.sv
// N-issue load-use interlock with intra-bundle split and stall watchdog.
// Optional STALL_CNT_EN adds a wrapping stall-cycle counter on stall_cnt_o.
module load_use_interlock_unit
    import pipe_pkg::*;
#(
    parameter int ISSUE_W  = 2,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int LOAD_LAT = 1,
    parameter int WDOG_MAX = 8
`ifdef STALL_CNT_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic                      clk,
    input  logic                      btnc_i,
    input  logic [ISSUE_W-1:0]        id_valid_i,
    input  logic [ISSUE_W*REG_AW-1:0] id_rs_i,
    input  logic [ISSUE_W*REG_AW-1:0] id_rt_i,
    input  logic [ISSUE_W-1:0]        id_rt_used_i,
    input  logic [ISSUE_W-1:0]        id_wr_i,
    input  logic [ISSUE_W*REG_AW-1:0] id_wd_i,
    input  logic [ISSUE_W-1:0]        ex_load_i,
    input  logic [ISSUE_W*REG_AW-1:0] ex_ld_rt_i,
    output logic                      stall_o,
    output logic                      bubble_o,
    output logic [ISSUE_W-1:0]        issue_mask_o,
    output logic                      err_o
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]          stall_cnt_o
`endif
);

    localparam int NUM_ENT = ISSUE_W * LOAD_LAT;
    localparam int WDOG_W  = $clog2(WDOG_MAX + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_MAX);

    // Entry a*ISSUE_W+k is slot k at age a; age 0 comes straight from ID/EX.
    pend_t [NUM_ENT-1:0] ents;

    genvar gi;
    generate
        for (gi = 0; gi < ISSUE_W; gi++) begin : g_age0
            assign ents[gi] = '{
                valid: ex_load_i[gi] && (ex_ld_rt_i[gi*REG_AW +: REG_AW] != '0),
                rt:    REG_AW_MAX'(ex_ld_rt_i[gi*REG_AW +: REG_AW])
            };
        end

        // EX/MEM never stalls, so older loads age every cycle regardless of stall_o.
        if (LOAD_LAT > 1) begin : g_sb
            pend_t [ISSUE_W*(LOAD_LAT-1)-1:0] sb_reg;

            always_ff @(posedge clk) begin
                if (btnc_i) begin
                    sb_reg <= '0;
                end else begin
                    sb_reg[ISSUE_W-1:0] <= ents[ISSUE_W-1:0];
                    for (int a = 2; a < LOAD_LAT; a++) begin
                        sb_reg[(a-1)*ISSUE_W +: ISSUE_W] <= sb_reg[(a-2)*ISSUE_W +: ISSUE_W];
                    end
                end
            end

            assign ents[NUM_ENT-1:ISSUE_W] = sb_reg;
        end
    endgenerate

    logic [ISSUE_W-1:0] rs_hit;
    logic [ISSUE_W-1:0] rt_hit;
    logic [ISSUE_W-1:0] src_hit;
    logic               lu_hit;

    generate
        for (gi = 0; gi < ISSUE_W; gi++) begin : g_cmp
            reg_match_cmp #(.NUM_ENT(NUM_ENT)) u_rs_cmp (
                .src  (REG_AW_MAX'(id_rs_i[gi*REG_AW +: REG_AW])),
                .ents (ents),
                .hit  (rs_hit[gi])
            );
            reg_match_cmp #(.NUM_ENT(NUM_ENT)) u_rt_cmp (
                .src  (REG_AW_MAX'(id_rt_i[gi*REG_AW +: REG_AW])),
                .ents (ents),
                .hit  (rt_hit[gi])
            );
            assign src_hit[gi] = id_valid_i[gi] & (rs_hit[gi] | (id_rt_used_i[gi] & rt_hit[gi]));
        end
    endgenerate

    assign lu_hit = |src_hit;

    // Split point: lowest slot that reads a nonzero destination written earlier in the bundle.
    int                 split_j;
    logic               dep;
    logic               split;
    logic [ISSUE_W-1:0] split_mask;

    always_comb begin
        split_j    = ISSUE_W;
        dep        = 1'b0;
        split_mask = '0;
        for (int j = ISSUE_W - 1; j >= 1; j--) begin
            dep = 1'b0;
            for (int i = 0; i < j; i++) begin
                if (id_valid_i[i] && id_wr_i[i] && (id_wd_i[i*REG_AW +: REG_AW] != '0) && id_valid_i[j] &&
                    ((id_rs_i[j*REG_AW +: REG_AW] == id_wd_i[i*REG_AW +: REG_AW]) ||
                     (id_rt_used_i[j] && (id_rt_i[j*REG_AW +: REG_AW] == id_wd_i[i*REG_AW +: REG_AW])))) begin
                    dep = 1'b1;
                end
            end
            if (dep) begin
                split_j = j;
            end
        end
        for (int k = 0; k < ISSUE_W; k++) begin
            split_mask[k] = id_valid_i[k] && (k < split_j);
        end
    end

    assign split = (split_j < ISSUE_W);

    always_comb begin
        stall_o      = 1'b0;
        bubble_o     = 1'b0;
        issue_mask_o = '0;
        if (!btnc_i) begin
            if (lu_hit) begin
                stall_o  = 1'b1;
                bubble_o = 1'b1;
            end else if (split) begin
                stall_o      = 1'b1;
                issue_mask_o = split_mask;
            end else begin
                issue_mask_o = id_valid_i;
            end
        end
    end

    lu_state_t         state_reg, state_next;
    logic [WDOG_W-1:0] wdog_reg, wdog_next;
    logic              err_reg, err_next;

    always_ff @(posedge clk) begin
        if (btnc_i) begin
            state_reg <= ST_RUN;
            wdog_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            wdog_reg  <= wdog_next;
            err_reg   <= err_next;
        end
    end

    // Only load-use stalls enter STALL; a split never feeds the watchdog.
    always_comb begin
        state_next = state_reg;
        wdog_next  = '0;
        err_next   = err_reg;
        case (state_reg)
            ST_RUN:   if (lu_hit)  state_next = ST_STALL;
            ST_STALL: if (!lu_hit) state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
        if (state_next == ST_STALL) begin
            wdog_next = (wdog_reg == WDOG_LIM) ? wdog_reg : wdog_reg + WDOG_W'(1);
        end
        if (wdog_next == WDOG_LIM) begin
            err_next = 1'b1;
        end
    end

    assign err_o = err_reg;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (btnc_i) begin
            stall_cnt_reg <= '0;
        end else if (stall_o) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_load_use_interlock_unit.sv
// Directed bench for load_use_interlock_unit: two instances (LOAD_LAT=1 and 3) on shared stimulus.
module tb_load_use_interlock_unit;

    logic       clk;
    logic       btnc;
    logic [1:0] id_valid;
    logic [9:0] id_rs;
    logic [9:0] id_rt;
    logic [1:0] id_rt_used;
    logic [1:0] id_wr;
    logic [9:0] id_wd;
    logic [1:0] ex_load;
    logic [9:0] ex_rt;

    logic       s1, b1, e1;
    logic [1:0] m1;
    logic       s3, b3, e3;
    logic [1:0] m3;
`ifdef STALL_CNT_EN
    logic [31:0] c1;
    logic [31:0] c3;
`endif

    int n_vec = 0;
    int n_bad = 0;

    load_use_interlock_unit #(.ISSUE_W(2), .REG_AW(5), .LOAD_LAT(1), .WDOG_MAX(8)) u1 (
        .clk          (clk),
        .btnc_i       (btnc),
        .id_valid_i   (id_valid),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_rt_used_i (id_rt_used),
        .id_wr_i      (id_wr),
        .id_wd_i      (id_wd),
        .ex_load_i    (ex_load),
        .ex_ld_rt_i   (ex_rt),
        .stall_o      (s1),
        .bubble_o     (b1),
        .issue_mask_o (m1),
        .err_o        (e1)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt_o  (c1)
`endif
    );

    load_use_interlock_unit #(.ISSUE_W(2), .REG_AW(5), .LOAD_LAT(3), .WDOG_MAX(8)) u3 (
        .clk          (clk),
        .btnc_i       (btnc),
        .id_valid_i   (id_valid),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_rt_used_i (id_rt_used),
        .id_wr_i      (id_wr),
        .id_wd_i      (id_wd),
        .ex_load_i    (ex_load),
        .ex_ld_rt_i   (ex_rt),
        .stall_o      (s3),
        .bubble_o     (b3),
        .issue_mask_o (m3),
        .err_o        (e3)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt_o  (c3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [1:0] v, input logic [4:0] rs0, input logic [4:0] rt0,
                          input logic [4:0] rs1, input logic [4:0] rt1, input logic [1:0] rtu,
                          input logic [1:0] wr, input logic [4:0] wd0, input logic [4:0] wd1);
        id_valid   = v;
        id_rs      = {rs1, rs0};
        id_rt      = {rt1, rt0};
        id_rt_used = rtu;
        id_wr      = wr;
        id_wd      = {wd1, wd0};
    endtask

    task automatic set_ex(input logic [1:0] ld, input logic [4:0] r0, input logic [4:0] r1);
        ex_load = ld;
        ex_rt   = {r1, r0};
    endtask

    task automatic idle();
        set_id(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        set_ex(2'b00, 0, 0);
    endtask

    initial begin
        // Reset with a live hazard on the inputs: outputs must stay quiet.
        btnc = 1'b1;
        set_ex(2'b01, 5, 0);
        set_id(2'b11, 5, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        step();
        step();
        chk("rst_stall", {31'd0, s1}, 0);
        chk("rst_bubble", {31'd0, b1}, 0);
        chk("rst_mask", {30'd0, m1}, 0);
        chk("rst_err", {31'd0, e1}, 0);
`ifdef STALL_CNT_EN
        chk("rst_cnt", c1, 0);
`endif
        btnc = 1'b0;
        idle();
        step();

        // Test 1: lw $5 in EX slot0, ID slot1 reads $5 as rs.
        set_ex(2'b01, 5, 0);
        set_id(2'b11, 1, 2, 5, 3, 2'b00, 2'b00, 0, 0);
        #1;
        chk("t1_stall", {31'd0, s1}, 1);
        chk("t1_bubble", {31'd0, b1}, 1);
        chk("t1_mask", {30'd0, m1}, 0);
        step();
        set_ex(2'b00, 0, 0);
        #1;
        chk("t1_release_stall", {31'd0, s1}, 0);
        chk("t1_release_mask", {30'd0, m1}, 2'b11);
        idle();
        step();
        step();
        step();

        // Test 2: LOAD_LAT=3, lw $7 in slot1, ID slot0 uses $7 as rt -> exactly 3 stall cycles.
        set_ex(2'b10, 0, 7);
        set_id(2'b11, 1, 7, 2, 3, 2'b01, 2'b00, 0, 0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("t2_stall_c%0d", c), {31'd0, s3}, (c < 3) ? 32'd1 : 32'd0);
            chk($sformatf("t2_mask_c%0d", c), {30'd0, m3}, (c < 3) ? 32'd0 : 32'd3);
            step();
            set_ex(2'b00, 0, 0);
        end
        idle();
        step();
        set_ex(2'b10, 0, 7);
        set_id(2'b11, 1, 7, 2, 3, 2'b00, 2'b00, 0, 0);
        #1;
        chk("t2_rtunused_stall", {31'd0, s3}, 0);
        chk("t2_rtunused_mask", {30'd0, m3}, 2'b11);
        idle();
        step();
        step();
        step();

        // Test 3: $0 never hazards, neither as a load target nor as an intra-bundle destination.
        set_ex(2'b01, 0, 0);
        set_id(2'b11, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0);
        #1;
        chk("t3_ld0_stall", {31'd0, s1}, 0);
        chk("t3_ld0_mask", {30'd0, m1}, 2'b11);
        step();
        set_ex(2'b00, 0, 0);
        set_id(2'b11, 1, 2, 0, 0, 2'b00, 2'b01, 0, 0);
        #1;
        chk("t3_wd0_stall_lat3", {31'd0, s3}, 0);
        chk("t3_wd0_mask", {30'd0, m1}, 2'b11);

        // Test 4: intra-bundle split, held long enough that a watchdog would trip if it counted.
        set_id(2'b11, 1, 2, 9, 3, 2'b00, 2'b01, 9, 0);
        #1;
        chk("t4_mask", {30'd0, m1}, 2'b01);
        chk("t4_stall", {31'd0, s1}, 1);
        chk("t4_bubble", {31'd0, b1}, 0);
        for (int i = 0; i < 10; i++) step();
        chk("t4_no_wdog", {31'd0, e1}, 0);
        set_id(2'b01, 1, 2, 9, 3, 2'b00, 2'b01, 9, 0);
        #1;
        chk("t4_slot1_invalid_mask", {30'd0, m1}, 2'b01);
        chk("t4_slot1_invalid_stall", {31'd0, s1}, 0);
        idle();
        step();

        // Test 5: persistent load-use stall trips the watchdog on the 8th cycle.
        set_ex(2'b01, 4, 0);
        set_id(2'b01, 4, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("t5_stall_c%0d", i), {31'd0, s1}, 1);
            if (i == 7) chk("t5_err_before", {31'd0, e1}, 0);
            step();
        end
        chk("t5_err_set", {31'd0, e1}, 1);
        idle();
        step();
        chk("t5_err_sticky", {31'd0, e1}, 1);
        chk("t5_idle_stall", {31'd0, s1}, 0);
        btnc = 1'b1;
        step();
        btnc = 1'b0;
        #1;
        chk("t5_err_cleared", {31'd0, e1}, 0);
`ifdef STALL_CNT_EN
        chk("t5_cnt_cleared", c1, 0);
        set_id(2'b11, 1, 2, 9, 3, 2'b00, 2'b01, 9, 0);
        step();
        step();
        chk("t5_cnt_two", c1, 2);
        idle();
`endif
        step();

        // Test 6: reset during the 2nd stall cycle of a LOAD_LAT=3 interlock.
        set_ex(2'b01, 7, 0);
        set_id(2'b11, 7, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        #1;
        chk("t6_c0_stall", {31'd0, s3}, 1);
        step();
        set_ex(2'b00, 0, 0);
        btnc = 1'b1;
        #1;
        chk("t6_in_reset_stall", {31'd0, s3}, 0);
        chk("t6_in_reset_mask", {30'd0, m3}, 0);
        step();
        btnc = 1'b0;
        #1;
        chk("t6_after_stall", {31'd0, s3}, 0);
        chk("t6_after_mask", {30'd0, m3}, 2'b11);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
